bambu_mp_ram_model: RTL
=======================

Name: bambu_mp_ram_model

Overview:
- Synthesizable, parametrised memory model for bambu-generated accelerators such as the IDCT kernels.
- Serves NUM_CH bambu minimal-memory-interface channels (oe/we/addr/wdata/size -> rdata/DataRdy) from one shared word array.
- Adds a configurable read/write latency, round-robin arbitration between channels, and correct sub-word size masking.
- A host port preloads the input matrix and dumps the result. It replaces per-testbench ad-hoc RAM logic and can also sit in FPGA demo wrappers.

Parameters:
- DATA_W, 16, word width in bits; must be 8, 16, 32 or 64.
- DEPTH, 64, number of words.
- ADDR_W, 32, byte-address width on the channel ports.
- NUM_CH, 2, number of accelerator channels (1..8).
- LATENCY, 1, cycles from grant to DataRdy pulse (1..4).
- SIZE_W, 5, width of the access-size field.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- ch_oe  in  NUM_CH  per-channel read enable
- ch_we  in  NUM_CH  per-channel write enable
- ch_addr  in  NUM_CH*ADDR_W  per-channel byte address
- ch_wdata  in  NUM_CH*DATA_W  per-channel write data
- ch_size  in  NUM_CH*SIZE_W  per-channel access size in bits
- ch_rdata  out  NUM_CH*DATA_W  per-channel read data, valid with ch_rdy
- ch_rdy  out  NUM_CH  per-channel one-cycle completion pulse (M_DataRdy)
- host_en  in  1  host access request
- host_we  in  1  host write (1) or read (0)
- host_addr  in  $clog2(DEPTH)  host word index
- host_wdata  in  DATA_W  host write data
- host_rdata  out  DATA_W  host read data, valid one cycle after host_en&!host_we
- err  out  1  one-cycle pulse on an illegal channel access

Behaviour:
- Reset:
  - ch_rdata=0, ch_rdy=0, host_rdata=0, err=0.
  - Arbiter pointer=0; pending bits and latency pipeline cleared.
  - Memory contents are not reset.
  - Reset mid-operation drops every in-flight access: no ch_rdy and no write commit for it.
- Request:
  - Channel i requests when (oe|we) is set and its pending bit is clear.
  - Requests are level-held by the master until ch_rdy[i].
- Arbitration:
  - At most one channel granted per cycle.
  - Round-robin starting at the pointer; the pointer moves to (granted+1) mod NUM_CH.
  - Grant sets pending[i]; pending[i] clears in the cycle ch_rdy[i] pulses.
  - host_en has absolute priority: no channel grant in that cycle, pointer unchanged.
- Decode:
  - Word index = addr >> log2(DATA_W/8).
  - Mask = (1<<size)-1 when size<DATA_W, else all ones (size=0 gives mask 0).
- Write (we&!oe): at grant, mem[idx] <= wdata & mask (whole word replaced). ch_rdy pulses LATENCY cycles after grant, ch_rdata=0.
- Read (oe&!we): mem[idx] is sampled at grant. ch_rdata = sampled & mask is presented with ch_rdy, LATENCY cycles after grant.
- Illegal access (oe&we both set, or idx>=DEPTH):
  - No memory write.
  - err pulses in the grant cycle.
  - ch_rdy still pulses after LATENCY with rdata 0, so the master never hangs.
- Ordering:
  - Read-after-write to the same word in a later grant returns the new data.
  - Host write and channel read in the same cycle cannot occur, because the host blocks grants.
- Host read: host_rdata = mem[host_addr] registered, one cycle later. host_addr>=DEPTH returns 0 with no err.
- Latency pipeline: LATENCY-stage shift register of {valid, ch_id, data}. Throughput is one access per cycle overall.
- ch_rdata[i] holds its last value between pulses.

Decomposition:
- Package bambu_mem_pkg:
  - SIZE_W constant;
  - size_mask(size, DATA_W) function;
  - typedef for the pipeline entry {valid, ch_id, rdata}.
- Sub-module bambu_rr_arbiter (NUM_CH-wide request/grant, pointer, hold input for host priority).

Test Plan:
- Host preload of the 64-entry IDCT input (word0=-240 i.e. 0xFF10, word63=-8), NUM_CH=1, LATENCY=1, read addr 0 size 16 -> ch_rdy one cycle after grant, rdata 0xFF10.
- Channel 0 writes 0x1234 at byte addr 6 with size 8 -> host read idx 3 returns 0x0034. Read back with size 16 returns 0x0034.
- NUM_CH=2, both channels request reads continuously from reset:
  - grants alternate 0,1,0,1;
  - each ch_rdy arrives LATENCY=3 cycles after its grant;
  - no channel is regranted while pending.
- host_en held 4 cycles during channel requests -> no channel grants in those cycles; pointer resumes unchanged afterwards.
- Illegal accesses:
  - addr 128 (idx 64) with DEPTH=64 -> err pulse, ch_rdy with rdata 0, memory unchanged;
  - oe&we both set -> same response.
- reset asserted one cycle after a write grant with LATENCY=2 -> no ch_rdy, all outputs 0 the next cycle.

Source files
------------

// File: rtl/bambu_mem_pkg.sv
// bambu_mem_pkg: shared constants, latency-pipeline entry type and sub-word mask helper
// for the bambu multi-port RAM model.
package bambu_mem_pkg;
  localparam int SIZE_W = 5;
  localparam int MAX_W = 64;
  localparam int CH_IDW = 3;
  typedef struct packed {
    logic valid;
    logic [CH_IDW-1:0] ch_id;
    logic [MAX_W-1:0] rdata;
  } pipe_t;
  // size 0 yields an empty mask; any size at or above the word width keeps the whole word
  function automatic logic [MAX_W-1:0] size_mask(input int size, input int data_w);
    return (size >= data_w) ? '1 : (64'd1 << size) - 64'd1;
  endfunction
endpackage

// File: rtl/bambu_mp_ram_model_if.sv
// bambu_mp_ram_model_if: bambu minimal-memory channels plus host port bundled into one bus.
// Channel side: ch_oe/ch_we/ch_addr/ch_wdata/ch_size -> ch_rdata/ch_rdy; host side:
// host_en/host_we/host_addr/host_wdata -> host_rdata; err flags an illegal channel access.
interface bambu_mp_ram_model_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 2,
  parameter int SIZE_W = bambu_mem_pkg::SIZE_W
);
  logic [NUM_CH-1:0] ch_oe, ch_we, ch_rdy;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata, ch_rdata;
  logic [NUM_CH*SIZE_W-1:0] ch_size;
  logic host_en, host_we, err;
  logic [$clog2(DEPTH)-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  modport master (
    output ch_oe, ch_we, ch_addr, ch_wdata, ch_size, host_en, host_we, host_addr, host_wdata,
    input ch_rdata, ch_rdy, host_rdata, err
  );
  modport slave (
    input ch_oe, ch_we, ch_addr, ch_wdata, ch_size, host_en, host_we, host_addr, host_wdata,
    output ch_rdata, ch_rdy, host_rdata, err
  );
endinterface

// File: rtl/bambu_rr_arbiter.sv
// bambu_rr_arbiter: single-grant round-robin arbiter.
// Ports: clock, reset (sync, active-high), req (per-channel requests), hold (blocks all grants
// and freezes the pointer), gnt (one-hot), gnt_id (granted index), gnt_valid.
module bambu_rr_arbiter #(
  parameter int NUM_CH = 2,
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              hold,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     gnt_id,
  output logic              gnt_valid
);
  logic [IW-1:0] ptr;
  // offset k scans outward from the pointer so the first hit is the round-robin winner
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    gnt_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      for (int i = 0; i < NUM_CH; i++)
        if (!gnt_valid && !hold && req[i] && i == (int'(ptr) + k) % NUM_CH) begin
          gnt_valid = 1'b1;
          gnt[i] = 1'b1;
          gnt_id = IW'(i);
        end
  end
  always_ff @(posedge clock) begin
    if (reset) ptr <= '0;
    else if (gnt_valid) ptr <= (int'(gnt_id) == NUM_CH - 1) ? '0 : gnt_id + IW'(1);
  end
endmodule

// File: rtl/bambu_mp_ram_model.sv
// bambu_mp_ram_model: shared word array serving NUM_CH bambu memory channels with round-robin
// arbitration, LATENCY-cycle completion and sub-word size masking, plus a host preload/dump port.
// Ports: clock, reset (sync, active-high), bus (slave side of bambu_mp_ram_model_if).
module bambu_mp_ram_model
  import bambu_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 2,
  parameter int LATENCY = 1,
  parameter int SIZE_W = bambu_mem_pkg::SIZE_W
) (
  input logic clock,
  input logic reset,
  bambu_mp_ram_model_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OFFS = $clog2(DATA_W / 8);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_CH-1:0] req, gnt, pending, rdy;
  logic [IW-1:0] gnt_id;
  logic gnt_valid, oe, we, illegal;
  logic [ADDR_W-1:0] addr, widx;
  logic [DATA_W-1:0] wdata, mask, host_q;
  logic [SIZE_W-1:0] size;
  logic [NUM_CH*DATA_W-1:0] held, rd_out;
  pipe_t in_e;
  pipe_t stg [LATENCY];
  // reset also holds the arbiter so nothing is granted or written while reset is high
  bambu_rr_arbiter #(.NUM_CH(NUM_CH)) arb (
    .clock(clock),
    .reset(reset),
    .req(req),
    .hold(bus.host_en | reset),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .gnt_valid(gnt_valid)
  );
  always_comb begin
    req = (bus.ch_oe | bus.ch_we) & ~pending;
    {oe, we, addr, wdata, size} = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt[i]) begin
        oe = bus.ch_oe[i];
        we = bus.ch_we[i];
        addr = bus.ch_addr[i*ADDR_W +: ADDR_W];
        wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
        size = bus.ch_size[i*SIZE_W +: SIZE_W];
      end
    widx = addr >> OFFS;
    illegal = (oe & we) | (widx >= ADDR_W'(DEPTH));
    mask = DATA_W'(size_mask(int'(size), DATA_W));
    in_e.valid = gnt_valid;
    in_e.ch_id = CH_IDW'(gnt_id);
    in_e.rdata = (oe & ~we & ~illegal) ? MAX_W'(mem[widx[AW-1:0]] & mask) : '0;
    // completion data is shown with the pulse and then held in 'held' until the next pulse
    for (int i = 0; i < NUM_CH; i++) begin
      rdy[i] = stg[LATENCY-1].valid && stg[LATENCY-1].ch_id == CH_IDW'(i);
      rd_out[i*DATA_W +: DATA_W] = rdy[i] ? stg[LATENCY-1].rdata[DATA_W-1:0] : held[i*DATA_W +: DATA_W];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
      held <= '0;
      host_q <= '0;
      for (int k = 0; k < LATENCY; k++) stg[k] <= '0;
    end else begin
      pending <= (pending | gnt) & ~rdy;
      held <= rd_out;
      stg[0] <= in_e;
      for (int k = 1; k < LATENCY; k++) stg[k] <= stg[k-1];
      if (bus.host_en && !bus.host_we) host_q <= int'(bus.host_addr) < DEPTH ? mem[bus.host_addr] : '0;
    end
  end
  always_ff @(posedge clock) begin
    if (bus.host_en && bus.host_we && int'(bus.host_addr) < DEPTH) mem[bus.host_addr] <= bus.host_wdata;
    if (gnt_valid && we && !oe && !illegal) mem[widx[AW-1:0]] <= wdata & mask;
  end
  assign bus.ch_rdy = rdy;
  assign bus.ch_rdata = rd_out;
  assign bus.host_rdata = host_q;
  assign bus.err = gnt_valid & illegal;
endmodule
